muldiv_unit: RTL

Parametrised iterative multiply/divide execution unit for the pipelined core's execute stage. It is the multi-cycle companion to the single-cycle ALU. It accepts one RISC-V M-extension operation per start pulse and computes it over a fixed number of cycles. It drives `busy` so the pipeline freezes (PC, IF/ID, ID/EX, EX/MEM and MEM/WB enables) and delivers a held result. Width is a parameter, and the operation can be aborted by a pipeline flush (branch/jump taken in MEM).

---
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit. Radix-2 shift-add multiply
// and restoring divide on operand magnitudes, followed by a sign/special-case fixup.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_r, nextState_s;
    logic [2:0]           op_r;
    logic [WIDTH-1:0]     aRaw_r, bRaw_r, operand_r, result_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic                 negA_r, negB_r, done_r;

    logic                 signedA_s, signedB_s, negAIn_s, negBIn_s;
    logic [WIDTH-1:0]     magA_s, magB_s;
    logic [WIDTH:0]       mulSum_s, divTrial_s;
    logic [2*WIDTH-1:0]   mulNext_s, divNext_s, prod_s;
    logic [WIDTH-1:0]     quo_s, rem_s, fix_s;
    logic                 divZero_s, overflow_s;

    function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    // Operand sign decode and magnitudes for the launch cycle
    always_comb begin
        signedA_s = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        signedB_s = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        negAIn_s  = signedA_s & a[WIDTH-1];
        negBIn_s  = signedB_s & b[WIDTH-1];
        magA_s    = negAIn_s ? negW(a) : a;
        magB_s    = negBIn_s ? negW(b) : b;
    end

    // One radix-2 step: acc holds {hi, multiplier} or {remainder, quotient}
    always_comb begin
        mulSum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}});
        mulNext_s  = {mulSum_s, acc_r[WIDTH-1:1]};
        divTrial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, operand_r};
        if (divTrial_s[WIDTH]) begin
            divNext_s = {acc_r[2*WIDTH-2:0], 1'b0};
        end else begin
            divNext_s = {divTrial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and divide special cases from the latched operands
    always_comb begin
        prod_s     = (negA_r ^ negB_r) ? neg2W(acc_r) : acc_r;
        quo_s      = (negA_r ^ negB_r) ? negW(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        rem_s      = negA_r ? negW(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
        divZero_s  = (bRaw_r == {WIDTH{1'b0}});
        overflow_s = ((op_r == 3'b100) || (op_r == 3'b110)) &&
                     (aRaw_r == {1'b1, {(WIDTH-1){1'b0}}}) && (bRaw_r == {WIDTH{1'b1}});
        case (op_r)
            3'b000:                 fix_s = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_s = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (divZero_s) begin
                    fix_s = {WIDTH{1'b1}};
                end else if (overflow_s) begin
                    fix_s = aRaw_r;
                end else begin
                    fix_s = quo_s;
                end
            end
            3'b110, 3'b111: begin
                if (divZero_s) begin
                    fix_s = aRaw_r;
                end else if (overflow_s) begin
                    fix_s = {WIDTH{1'b0}};
                end else begin
                    fix_s = rem_s;
                end
            end
            default: fix_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !flush) begin
                    nextState_s = CALC;
                end else begin
                    nextState_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    nextState_s = IDLE;
                end else if (cnt_r == CW'(WIDTH - 1)) begin
                    nextState_s = FIX;
                end else begin
                    nextState_s = CALC;
                end
            end
            FIX: begin
                if (flush) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = DONE;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            op_r      <= 3'b000;
            aRaw_r    <= {WIDTH{1'b0}};
            bRaw_r    <= {WIDTH{1'b0}};
            operand_r <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CW{1'b0}};
            negA_r    <= 1'b0;
            negB_r    <= 1'b0;
            result_r  <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
        end else begin
            state_r <= nextState_s;
            done_r  <= (nextState_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start && !flush) begin
                        op_r   <= op;
                        aRaw_r <= a;
                        bRaw_r <= b;
                        negA_r <= negAIn_s;
                        negB_r <= negBIn_s;
                        cnt_r  <= {CW{1'b0}};
                        if (op[2]) begin
                            operand_r <= magB_s;
                            acc_r     <= {{WIDTH{1'b0}}, magA_s};
                        end else begin
                            operand_r <= magA_s;
                            acc_r     <= {{WIDTH{1'b0}}, magB_s};
                        end
                    end
                end
                CALC: begin
                    acc_r <= op_r[2] ? divNext_s : mulNext_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                FIX: begin
                    if (!flush) begin
                        result_r <= fix_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_r == CALC) || (state_r == FIX) || ((state_r == IDLE) && start && !flush);
    assign done   = done_r;
    assign result = result_r;

endmodule
